// File: rtl/rotary_knob_decoder_if.sv
// Pin and detent-output bundle between the encoder front end and its consumers.
// ROTARY_POS_COUNT_EN adds the signed detent position to the bundle.
interface rotary_knob_decoder_if;
    logic       ROT_A;
    logic       ROT_B;
    logic       rotation_event;
    logic       rotation_left;
    logic       event_pulse;
`ifdef ROTARY_POS_COUNT_EN
    logic [7:0] position;

    modport master (
        output ROT_A, ROT_B,
        input  rotation_event, rotation_left, event_pulse, position
    );

    modport slave (
        input  ROT_A, ROT_B,
        output rotation_event, rotation_left, event_pulse, position
    );
`else
    modport master (
        output ROT_A, ROT_B,
        input  rotation_event, rotation_left, event_pulse
    );

    modport slave (
        input  ROT_A, ROT_B,
        output rotation_event, rotation_left, event_pulse
    );
`endif
endinterface

// File: rtl/rotary_knob_decoder.sv
// Synchronises, debounces and quadrature-decodes the rotary encoder pins into a detent level, pulse and direction.
// Optional feature macro: ROTARY_POS_COUNT_EN (adds an 8-bit signed detent position counter).
module rotary_knob_decoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    rotary_knob_decoder_if.slave enc
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      initCnt_q, initCnt_d;
    logic            inInit;

    // Bit 1 carries pin A, bit 0 carries pin B throughout the datapath.
    logic [1:0]      meta_q, meta_d;
    logic [1:0]      sync_q, sync_d;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][7:0] cnt_q, cnt_d;
    logic            q1_q, q1_d;
    logic            q2_q, q2_d;
    logic            q1Prev_q, q1Prev_d;
    logic            pulse_q, pulse_d;
    logic            left_q, left_d;
    logic            detent;
    logic            fA, fB;
`ifdef ROTARY_POS_COUNT_EN
    logic [7:0]      pos_q, pos_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    // INIT lasts four cycles so the pins reach the filters before detents are reported.
    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        case (state_q)
            INIT: begin
                initCnt_d = initCnt_q + 3'd1;
                if (initCnt_q == 3'd3) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        inInit = (state_q == INIT);
    end

    always_comb begin
        meta_d = {enc.ROT_A, enc.ROT_B};
        sync_d = meta_q;
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (inInit) begin
                filt_d[i] = sync_q[i];
                cnt_d[i]  = '0;
            end else if (sync_q[i] == filt_q[i]) begin
                cnt_d[i]  = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i]  = cnt_q[i] + 8'd1;
            end
        end

        fA   = filt_q[1];
        fB   = filt_q[0];
        q1_d = q1_q;
        q2_d = q2_q;
        if (fA && fB) begin
            q1_d = 1'b1;
        end else if (!fA && !fB) begin
            q1_d = 1'b0;
        end
        if (!fA && fB) begin
            q2_d = 1'b1;
        end else if (fA && !fB) begin
            q2_d = 1'b0;
        end

        // During INIT the edge reference follows q1 so pins resting at 11 are not seen as a rising detent.
        detent   = q1_q && !q1Prev_q && !inInit;
        q1Prev_d = inInit ? q1_d : q1_q;
        pulse_d  = detent;
        left_d   = detent ? q2_q : left_q;
`ifdef ROTARY_POS_COUNT_EN
        pos_d = pos_q;
        if (detent) begin
            pos_d = q2_q ? (pos_q - 8'd1) : (pos_q + 8'd1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            q1_q     <= 1'b0;
            q2_q     <= 1'b0;
            q1Prev_q <= 1'b0;
            pulse_q  <= 1'b0;
            left_q   <= 1'b0;
`ifdef ROTARY_POS_COUNT_EN
            pos_q    <= '0;
`endif
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            q1_q     <= q1_d;
            q2_q     <= q2_d;
            q1Prev_q <= q1Prev_d;
            pulse_q  <= pulse_d;
            left_q   <= left_d;
`ifdef ROTARY_POS_COUNT_EN
            pos_q    <= pos_d;
`endif
        end
    end

    assign enc.rotation_event = q1_q;
    assign enc.rotation_left  = left_q;
    assign enc.event_pulse    = pulse_q;
`ifdef ROTARY_POS_COUNT_EN
    assign enc.position       = pos_q;
`endif

endmodule
